trap_sequencer: RTL
===================

// Module: trap_sequencer
// PURPOSE
// - Machine-mode trap/return controller between the commit stage and csr_regfile.
// - Arbitrates synchronous exceptions, M external/timer interrupts and mret.
// - Sequences flush -> pipeline drain -> CSR update pulse -> PC redirect handshake.
// - Presents the regfile one registered write bundle per trap (cause/epc/tval) or return.
// PARAMETERS
// - XLEN       32  datapath width
// - DRAIN_MAX  15  maximum DRAIN cycles before forced commit; counter width = $clog2(DRAIN_MAX+1)
// PORTS
// - clk             in   1     clock
// - nrst            in   1     asynchronous reset, active-low
// - exc_valid       in   1     commit stage reports a synchronous exception
// - exc_code        in   5     exception cause code
// - exc_tval        in   XLEN  faulting address/instruction
// - commit_pc       in   XLEN  pc of oldest uncommitted instruction
// - mret_valid      in   1     mret reached commit
// - m_eie, m_tie    in   1     enabled+pending M external / timer interrupt (already gated by mstatus.MIE)
// - mtvec_base      in   XLEN-2  mtvec[XLEN-1:2]
// - mtvec_mode      in   1     mtvec[0]; used only with TRAP_VECTORED_EN
// - mepc_in         in   XLEN  current mepc
// - pipe_empty      in   1     all younger instructions squashed, no outstanding memory ops
// - redirect_ready  in   1     fetch accepts redirect
// - flush           out  1     squash pipeline (one-cycle pulse)
// - trap_we         out  1     one-cycle pulse: regfile takes trap entry (mepc, mcause, mtval, mstatus stack)
// - ret_we          out  1     one-cycle pulse: regfile performs mret mstatus unstack
// - trap_cause      out  XLEN  mcause value; bit XLEN-1 = interrupt
// - trap_epc        out  XLEN  value for mepc, bits[1:0] = 0
// - trap_tval       out  XLEN  value for mtval
// - redirect_valid  out  1     redirect_pc valid; held until accepted
// - redirect_pc     out  XLEN  new fetch pc
// - busy            out  1     state != IDLE
// - drain_err       out  1     sticky: DRAIN hit DRAIN_MAX
// BEHAVIOUR
// - Reset: state IDLE; every output 0, including drain_err and the latched cause/epc/tval/pc registers.
// - States: IDLE, DRAIN, COMMIT, REDIRECT; all outputs are registered.
// - IDLE arbitration, sampled cycle N, highest priority first:
//   - exc_valid: cause = {0, exc_code}; tval = exc_tval.
//   - m_eie: cause = {1, 11}; tval = 0.
//   - m_tie: cause = {1, 7}; tval = 0.
//   - mret_valid: return.
// - On any accept: latch cause, epc = {commit_pc[XLEN-1:2], 2'b00}, tval and kind (trap/ret).
//   - N+1: flush = 1 for one cycle, state DRAIN, drain counter cleared.
//   - No accept: stay IDLE, flush = 0.
// - DRAIN:
//   - pipe_empty = 1: -> COMMIT.
//   - Otherwise increment counter; at DRAIN_MAX -> COMMIT and set drain_err (cleared only by reset).
// - COMMIT: one cycle.
//   - Trap: trap_we = 1. redirect_pc = {mtvec_base, 2'b00}.
//   - Return: ret_we = 1. redirect_pc = {mepc_in[XLEN-1:2], 2'b00}, mepc sampled in COMMIT.
//   - -> REDIRECT.
// - REDIRECT: redirect_valid = 1 and redirect_pc stable until redirect_ready = 1, then -> IDLE next cycle.
//   - redirect_ready already high: redirect_valid lasts exactly one cycle.
// - Minimum trap latency, pipe_empty high: accept N, flush N+1, trap_we N+2, redirect_valid N+3, IDLE N+4.
// - Outside IDLE: all exc/irq/mret inputs ignored; interrupts still pending are re-arbitrated on return to IDLE.
// - trap_cause/trap_epc/trap_tval hold their latched values from accept until the next accept.
// - nrst low mid-sequence: immediate return to IDLE, all outputs 0; no partial trap_we/ret_we.
// CONFIGURATION
// - TRAP_VECTORED_EN defined, mtvec_mode = 1, interrupt trap: redirect_pc = {mtvec_base, 2'b00} + 4*cause[4:0].
//   - Exceptions always go to the base.
// - TRAP_VECTORED_EN undefined: direct mode only; mtvec_mode ignored.
// TESTING
// - Exception: exc_valid = 1, code 2, commit_pc 0x100, tval 0xDEAD, mtvec 0x200, pipe_empty = 1.
//   -> flush N+1; trap_we N+2 with cause 0x2, epc 0x100, tval 0xDEAD; redirect_pc 0x200 at N+3.
// - Simultaneous exc_valid, m_eie, m_tie, mret_valid -> exception wins.
//   - m_eie then taken on next IDLE: cause 0x8000000B, tval 0.
// - mret, mepc_in 0x344 -> ret_we pulse, no trap_we, redirect_pc 0x344.
// - pipe_empty held 0, DRAIN_MAX = 15 -> COMMIT after 15 DRAIN cycles; drain_err = 1 and stays 1.
// - redirect_ready low 3 cycles -> redirect_valid and redirect_pc stable 4 cycles, then IDLE.
// - TRAP_VECTORED_EN, mtvec_mode = 1, base 0x1000, m_tie -> redirect_pc 0x101C.
//   - Reset asserted in DRAIN -> all outputs 0, busy = 0.

Source files
------------

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - M-mode trap/mret sequencer: arbitrate, flush, drain, CSR write pulse, PC redirect (TRAP_VECTORED_EN enables vectored interrupts)
module trap_sequencer #(
    parameter int XLEN      = 32,
    parameter int DRAIN_MAX = 15
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            exc_valid,
    input  logic [4:0]      exc_code,
    input  logic [XLEN-1:0] exc_tval,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            mret_valid,
    input  logic            m_eie,
    input  logic            m_tie,
    input  logic [XLEN-3:0] mtvec_base,
    input  logic            mtvec_mode,
    input  logic [XLEN-1:0] mepc_in,
    input  logic            pipe_empty,
    input  logic            redirect_ready,
    output logic            flush,
    output logic            trap_we,
    output logic            ret_we,
    output logic [XLEN-1:0] trap_cause,
    output logic [XLEN-1:0] trap_epc,
    output logic [XLEN-1:0] trap_tval,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy,
    output logic            drain_err
);

    localparam int CNT_W = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_ret_q, is_ret_d;
    logic              flush_q, flush_d;
    logic              trap_we_q, trap_we_d;
    logic              ret_we_q, ret_we_d;
    logic [XLEN-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   tval_q, tval_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              busy_q, busy_d;
    logic              drain_err_q, drain_err_d;

    logic              accept;
    logic [CNT_W-1:0]  cnt_inc;
    logic              drain_timeout;
    logic [XLEN-1:0]   trap_target;

    assign accept        = exc_valid | m_eie | m_tie | mret_valid;
    assign cnt_inc       = cnt_q + CNT_W'(1);
    assign drain_timeout = (cnt_inc == CNT_W'(DRAIN_MAX));

`ifdef TRAP_VECTORED_EN
    // Interrupts jump to base + 4*code when vectored; exceptions always use the base.
    assign trap_target = (mtvec_mode && cause_q[XLEN-1])
                       ? ({mtvec_base, 2'b00} + {{(XLEN-7){1'b0}}, cause_q[4:0], 2'b00})
                       : {mtvec_base, 2'b00};
    logic unused_bits;
    assign unused_bits = ^{mepc_in[1:0], commit_pc[1:0]};
`else
    // Direct mode only: every trap lands on the base.
    assign trap_target = {mtvec_base, 2'b00};
    logic unused_bits;
    assign unused_bits = ^{mepc_in[1:0], commit_pc[1:0], mtvec_mode};
`endif

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = DRAIN;
            DRAIN:    if (pipe_empty || drain_timeout) state_d = COMMIT;
            COMMIT:   state_d = REDIRECT;
            REDIRECT: if (redirect_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output and datapath next values; everything leaves the block from a flop.
    always_comb begin
        cnt_d            = cnt_q;
        is_ret_d         = is_ret_q;
        flush_d          = 1'b0;
        trap_we_d        = 1'b0;
        ret_we_d         = 1'b0;
        cause_d          = cause_q;
        epc_d            = epc_q;
        tval_d           = tval_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        busy_d           = (state_d != IDLE);
        drain_err_d      = drain_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    flush_d  = 1'b1;
                    cnt_d    = '0;
                    epc_d    = {commit_pc[XLEN-1:2], 2'b00};
                    is_ret_d = 1'b0;
                    if (exc_valid) begin
                        cause_d = {{(XLEN-5){1'b0}}, exc_code};
                        tval_d  = exc_tval;
                    end else if (m_eie) begin
                        cause_d = {1'b1, {(XLEN-6){1'b0}}, 5'd11};
                        tval_d  = '0;
                    end else if (m_tie) begin
                        cause_d = {1'b1, {(XLEN-6){1'b0}}, 5'd7};
                        tval_d  = '0;
                    end else begin
                        is_ret_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!pipe_empty) begin
                    cnt_d = cnt_inc;
                    if (drain_timeout) drain_err_d = 1'b1;
                end
                if (state_d == COMMIT) begin
                    trap_we_d = ~is_ret_q;
                    ret_we_d  = is_ret_q;
                end
            end
            COMMIT: begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = is_ret_q ? {mepc_in[XLEN-1:2], 2'b00} : trap_target;
            end
            REDIRECT: begin
                if (redirect_ready) redirect_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q            <= '0;
            is_ret_q         <= 1'b0;
            flush_q          <= 1'b0;
            trap_we_q        <= 1'b0;
            ret_we_q         <= 1'b0;
            cause_q          <= '0;
            epc_q            <= '0;
            tval_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            busy_q           <= 1'b0;
            drain_err_q      <= 1'b0;
        end else begin
            cnt_q            <= cnt_d;
            is_ret_q         <= is_ret_d;
            flush_q          <= flush_d;
            trap_we_q        <= trap_we_d;
            ret_we_q         <= ret_we_d;
            cause_q          <= cause_d;
            epc_q            <= epc_d;
            tval_q           <= tval_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            busy_q           <= busy_d;
            drain_err_q      <= drain_err_d;
        end
    end

    assign flush          = flush_q;
    assign trap_we        = trap_we_q;
    assign ret_we         = ret_we_q;
    assign trap_cause     = cause_q;
    assign trap_epc       = epc_q;
    assign trap_tval      = tval_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign busy           = busy_q;
    assign drain_err      = drain_err_q;

endmodule
